duck_round_ctrl: RTL and testbench

Game-round controller that sits directly upstream of the colour mapper. It turns mouse clicks, cursor position, duck position and a per-frame tick into game state:
- menu/play background select
- start pulse
- shots-used count
- per-duck hit/miss tally
- hit/escape pulses for the duck motion block

All outputs are registered, so the mapper's drawing logic only decodes stable state.

---
 rtl/duck_round_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_duck_round_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/duck_round_ctrl.sv
// Game-round controller: click edge detection, hit/menu tests and the
// MENU/FLY/RESULT/GAME_OVER sequencing; every output is a register.
module duck_round_ctrl #(
   parameter int MENU_X0      = 200,
   parameter int MENU_X1      = 300,
   parameter int MENU_Y0      = 200,
   parameter int MENU_Y1      = 250,
   parameter int DUCK_SIZE    = 64,
   parameter int SHOTS        = 3,
   parameter int FLY_FRAMES   = 300,
   parameter int PAUSE_FRAMES = 60,
   parameter int NUM_DUCKS    = 10
) (
   input  logic                     vga_clk,
   input  logic                     Reset,
   input  logic                     frame_tick,
   input  logic [7:0]               MouseButtons,
   input  logic [9:0]               BallX,
   input  logic [9:0]               BallY,
   input  logic [9:0]               Duck_X,
   input  logic [9:0]               Duck_Y,
   output logic [1:0]               background,
   output logic                     start_game_signal,
   output logic [1:0]               shots_used,
   output logic [3:0]               duck_index,
   output logic [2*NUM_DUCKS-1:0]   duck_status,
   output logic [3:0]               hits,
   output logic                     duck_hit,
   output logic                     duck_escape,
   output logic                     game_over
);

   localparam int FLY_W   = (FLY_FRAMES > 2) ? $clog2(FLY_FRAMES) : 1;
   localparam int PAUSE_W = (PAUSE_FRAMES > 2) ? $clog2(PAUSE_FRAMES) : 1;

   typedef enum logic [1:0] {
      S_MENU   = 2'd0,
      S_FLY    = 2'd1,
      S_RESULT = 2'd2,
      S_OVER   = 2'd3
   } state_t;

   state_t                 r_state;
   logic [1:0]             r_background;
   logic                   r_start;
   logic [1:0]             r_shots;
   logic [3:0]             r_idx;
   logic [2*NUM_DUCKS-1:0] r_status;
   logic [3:0]             r_hits;
   logic                   r_hit;
   logic                   r_escape;
   logic                   r_over;
   logic [FLY_W-1:0]       r_fly_cnt;
   logic [PAUSE_W-1:0]     r_pause_cnt;
   logic                   r_click_now;
   logic                   r_click_prev;
   logic                   r_armed;

   logic        w_btn, w_click, w_in_duck, w_in_menu;
   logic        w_last_shot, w_fly_last, w_pause_last, w_idx_last;
   logic [1:0]  w_shots_inc;
   logic [10:0] w_bx, w_by, w_dx, w_dy;

   assign w_btn = (MouseButtons == 8'd2);
   // r_armed stays low until the button is seen released after reset, so a
   // button held through reset cannot produce a click on the first edges.
   assign w_click = r_click_now & ~r_click_prev & r_armed;

   assign w_bx = {1'b0, BallX};
   assign w_by = {1'b0, BallY};
   assign w_dx = {1'b0, Duck_X};
   assign w_dy = {1'b0, Duck_Y};

   assign w_in_duck = (w_bx >= w_dx) && (w_bx < w_dx + 11'(DUCK_SIZE)) &&
                      (w_by >= w_dy) && (w_by < w_dy + 11'(DUCK_SIZE));
   assign w_in_menu = (w_bx >= 11'(MENU_X0)) && (w_bx < 11'(MENU_X1)) &&
                      (w_by >= 11'(MENU_Y0)) && (w_by < 11'(MENU_Y1));

   assign w_shots_inc  = (r_shots == 2'(SHOTS)) ? r_shots : r_shots + 2'd1;
   assign w_last_shot  = (w_shots_inc == 2'(SHOTS));
   assign w_fly_last   = frame_tick && (r_fly_cnt == FLY_W'(FLY_FRAMES - 1));
   assign w_pause_last = frame_tick && (r_pause_cnt == PAUSE_W'(PAUSE_FRAMES - 1));
   assign w_idx_last   = (r_idx == 4'(NUM_DUCKS - 1));

   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         r_state      <= S_MENU;
         r_background <= 2'b00;
         r_start      <= 1'b0;
         r_shots      <= '0;
         r_idx        <= '0;
         r_status     <= '0;
         r_hits       <= '0;
         r_hit        <= 1'b0;
         r_escape     <= 1'b0;
         r_over       <= 1'b0;
         r_fly_cnt    <= '0;
         r_pause_cnt  <= '0;
         r_click_now  <= 1'b0;
         r_click_prev <= 1'b1;
         r_armed      <= 1'b0;
      end else begin
         r_click_now  <= w_btn;
         r_click_prev <= r_click_now;
         r_armed      <= r_armed | ~w_btn;
         r_start      <= 1'b0;
         r_hit        <= 1'b0;
         r_escape     <= 1'b0;

         case (r_state)
            S_MENU: begin
               if (w_click && w_in_menu) begin
                  r_start      <= 1'b1;
                  r_status     <= '0;
                  r_hits       <= '0;
                  r_idx        <= '0;
                  r_shots      <= '0;
                  r_fly_cnt    <= '0;
                  r_pause_cnt  <= '0;
                  r_background <= 2'b01;
                  r_state      <= S_FLY;
               end
            end

            S_FLY: begin
               if (frame_tick) r_fly_cnt <= r_fly_cnt + FLY_W'(1);
               if (w_click) r_shots <= w_shots_inc;
               // A hit outranks a coincident timeout; any escape cause gives one pulse.
               if (w_click && w_in_duck) begin
                  for (int unsigned k = 0; k < NUM_DUCKS; k++)
                     if (r_idx == 4'(k)) r_status[2*k +: 2] <= 2'b10;
                  r_hits  <= (r_hits == 4'hF) ? r_hits : r_hits + 4'd1;
                  r_hit   <= 1'b1;
                  r_state <= S_RESULT;
               end else if ((w_click && w_last_shot) || w_fly_last) begin
                  for (int unsigned k = 0; k < NUM_DUCKS; k++)
                     if (r_idx == 4'(k)) r_status[2*k +: 2] <= 2'b01;
                  r_escape <= 1'b1;
                  r_state  <= S_RESULT;
               end
            end

            S_RESULT: begin
               if (w_pause_last) begin
                  r_pause_cnt <= '0;
                  if (w_idx_last) begin
                     r_over  <= 1'b1;
                     r_state <= S_OVER;
                  end else begin
                     r_idx     <= r_idx + 4'd1;
                     r_shots   <= '0;
                     r_fly_cnt <= '0;
                     r_state   <= S_FLY;
                  end
               end else if (frame_tick) begin
                  r_pause_cnt <= r_pause_cnt + PAUSE_W'(1);
               end
            end

            S_OVER: begin
               if (w_click) begin
                  r_over       <= 1'b0;
                  r_background <= 2'b00;
                  r_state      <= S_MENU;
               end
            end

            default: r_state <= S_MENU;
         endcase
      end
   end

   assign background        = r_background;
   assign start_game_signal = r_start;
   assign shots_used        = r_shots;
   assign duck_index        = r_idx;
   assign duck_status       = r_status;
   assign hits              = r_hits;
   assign duck_hit          = r_hit;
   assign duck_escape       = r_escape;
   assign game_over         = r_over;

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Directed bench for duck_round_ctrl: menu start, hits, misses, timeouts,
// full games and reset behaviour, against hand-derived expectations.
module tb_duck_round_ctrl;

   logic        vga_clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic [7:0]  MouseButtons = 8'd0;
   logic [9:0]  BallX = 10'd0, BallY = 10'd0;
   logic [9:0]  Duck_X = 10'd100, Duck_Y = 10'd100;
   logic [1:0]  background;
   logic        start_game_signal;
   logic [1:0]  shots_used;
   logic [3:0]  duck_index;
   logic [19:0] duck_status;
   logic [3:0]  hits;
   logic        duck_hit, duck_escape, game_over;

   int          n_vec = 0;
   int          n_err = 0;
   logic [19:0] exp_status;
   int          exp_hits;

   duck_round_ctrl dut (
      .vga_clk           (vga_clk),
      .Reset             (Reset),
      .frame_tick        (frame_tick),
      .MouseButtons      (MouseButtons),
      .BallX             (BallX),
      .BallY             (BallY),
      .Duck_X            (Duck_X),
      .Duck_Y            (Duck_Y),
      .background        (background),
      .start_game_signal (start_game_signal),
      .shots_used        (shots_used),
      .duck_index        (duck_index),
      .duck_status       (duck_status),
      .hits              (hits),
      .duck_hit          (duck_hit),
      .duck_escape       (duck_escape),
      .game_over         (game_over)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge vga_clk);
   endtask

   // Press for one sample; returns at the negedge after the state update.
   task automatic do_click(input logic [9:0] x, input logic [9:0] y);
      @(negedge vga_clk);
      BallX = x; BallY = y; MouseButtons = 8'd2;
      @(negedge vga_clk);
      MouseButtons = 8'd0;
      @(negedge vga_clk);
   endtask

   // Click whose edge-detect cycle coincides with a frame tick.
   task automatic click_tick(input logic [9:0] x, input logic [9:0] y);
      @(negedge vga_clk);
      BallX = x; BallY = y; MouseButtons = 8'd2;
      @(negedge vga_clk);
      MouseButtons = 8'd0; frame_tick = 1'b1;
      @(negedge vga_clk);
      frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(negedge vga_clk);
         frame_tick = 1'b1;
         @(negedge vga_clk);
         frame_tick = 1'b0;
      end
   endtask

   task automatic end_round(input int k);
      ticks(60);
      if (k < 9) begin
         check("next_idx", 32'(duck_index), k + 1);
         check("next_shots", 32'(shots_used), 0);
      end else begin
         check("game_over", 32'(game_over), 1);
         check("over_bg", 32'(background), 1);
      end
   endtask

   task automatic hit_round(input int k);
      do_click(10'd130, 10'd130);
      exp_status[2*k +: 2] = 2'b10;
      exp_hits++;
      check("hit_pulse", 32'(duck_hit), 1);
      check("hit_noesc", 32'(duck_escape), 0);
      check("hit_status", 32'(duck_status), 32'(exp_status));
      check("hit_count", 32'(hits), exp_hits);
      end_round(k);
   endtask

   task automatic miss_round(input int k);
      do_click(10'd0, 10'd0);
      do_click(10'd0, 10'd0);
      check("miss2_noesc", 32'(duck_escape), 0);
      do_click(10'd0, 10'd0);
      exp_status[2*k +: 2] = 2'b01;
      check("miss3_shots", 32'(shots_used), 3);
      check("miss3_esc", 32'(duck_escape), 1);
      check("miss3_status", 32'(duck_status), 32'(exp_status));
      end_round(k);
   endtask

   initial begin
      exp_status = '0;
      exp_hits = 0;
      step(3);
      check("rst_bg", 32'(background), 0);
      check("rst_start", 32'(start_game_signal), 0);
      check("rst_shots", 32'(shots_used), 0);
      check("rst_idx", 32'(duck_index), 0);
      check("rst_status", 32'(duck_status), 0);
      check("rst_hits", 32'(hits), 0);
      check("rst_pulses", 32'({duck_hit, duck_escape, game_over}), 0);
      Reset = 1'b0;
      step(2);

      // Menu button edges
      do_click(10'd199, 10'd225);
      check("menu_left_out", 32'({start_game_signal, background}), 0);
      do_click(10'd250, 10'd250);
      check("menu_bottom_out", 32'({start_game_signal, background}), 0);
      do_click(10'd300, 10'd225);
      check("menu_right_out", 32'({start_game_signal, background}), 0);
      do_click(10'd200, 10'd200);
      check("start_pulse", 32'(start_game_signal), 1);
      check("start_bg", 32'(background), 1);
      check("start_idx", 32'(duck_index), 0);
      step(1);
      check("start_width", 32'(start_game_signal), 0);

      // Duck 0: boundary miss then corner hit
      do_click(10'd164, 10'd100);
      check("miss_edge_shots", 32'(shots_used), 1);
      check("miss_edge_pulses", 32'({duck_hit, duck_escape}), 0);
      check("miss_edge_bg", 32'(background), 1);
      do_click(10'd163, 10'd163);
      exp_status[1:0] = 2'b10; exp_hits = 1;
      check("corner_hit", 32'(duck_hit), 1);
      check("corner_status", 32'(duck_status), 32'(exp_status));
      check("corner_hits", 32'(hits), 1);
      check("corner_shots", 32'(shots_used), 2);
      step(1);
      check("hit_width", 32'(duck_hit), 0);
      do_click(10'd130, 10'd130);
      check("result_ignores", 32'(hits), 1);
      ticks(59);
      check("pause59_idx", 32'(duck_index), 0);
      ticks(1);
      check("pause60_idx", 32'(duck_index), 1);
      check("pause60_shots", 32'(shots_used), 0);

      // Duck 1: out of shots, near-edge misses
      do_click(10'd99, 10'd130);
      do_click(10'd130, 10'd99);
      check("two_miss_esc", 32'(duck_escape), 0);
      do_click(10'd0, 10'd0);
      exp_status[3:2] = 2'b01;
      check("oos_shots", 32'(shots_used), 3);
      check("oos_esc", 32'(duck_escape), 1);
      check("oos_status", 32'(duck_status), 32'(exp_status));
      ticks(60);
      check("d2_idx", 32'(duck_index), 2);

      // Duck 2: pure timeout
      ticks(299);
      check("t299_noesc", 32'(duck_escape), 0);
      ticks(1);
      exp_status[5:4] = 2'b01;
      check("t300_esc", 32'(duck_escape), 1);
      check("t300_status", 32'(duck_status), 32'(exp_status));
      step(1);
      check("t300_width", 32'(duck_escape), 0);
      ticks(60);
      check("d3_idx", 32'(duck_index), 3);

      // Duck 3: hit on the timeout tick
      ticks(299);
      click_tick(10'd130, 10'd130);
      exp_status[7:6] = 2'b10; exp_hits = 2;
      check("tie_hit", 32'(duck_hit), 1);
      check("tie_noesc", 32'(duck_escape), 0);
      check("tie_status", 32'(duck_status), 32'(exp_status));
      check("tie_hits", 32'(hits), 2);
      ticks(60);
      check("d4_idx", 32'(duck_index), 4);

      // Duck 4: miss on the timeout tick gives a single escape
      ticks(299);
      click_tick(10'd0, 10'd0);
      exp_status[9:8] = 2'b01;
      check("tiemiss_esc", 32'(duck_escape), 1);
      check("tiemiss_shots", 32'(shots_used), 1);
      check("tiemiss_status", 32'(duck_status), 32'(exp_status));
      step(1);
      check("tiemiss_once", 32'(duck_escape), 0);
      ticks(60);
      check("d5_idx", 32'(duck_index), 5);

      for (int k = 5; k < 10; k++) hit_round(k);
      do_click(10'd0, 10'd0);
      check("g1_menu_bg", 32'(background), 0);
      check("g1_menu_over", 32'(game_over), 0);
      check("g1_status_held", 32'(duck_status), 32'(exp_status));
      check("g1_hits_held", 32'(hits), 7);

      // Second game: alternating hit/miss
      do_click(10'd250, 10'd225);
      exp_status = '0; exp_hits = 0;
      check("g2_start", 32'(start_game_signal), 1);
      check("g2_status_clr", 32'(duck_status), 0);
      check("g2_hits_clr", 32'(hits), 0);
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0) hit_round(k);
         else miss_round(k);
      end
      check("g2_status", 32'(duck_status), 32'h66666);
      check("g2_hits", 32'(hits), 5);
      do_click(10'd10, 10'd10);
      check("g2_menu_bg", 32'(background), 0);
      check("g2_status_kept", 32'(duck_status), 32'h66666);

      // Reset during a hit pulse, then button held across reset release
      do_click(10'd250, 10'd225);
      do_click(10'd130, 10'd130);
      check("pre_rst_hit", 32'(duck_hit), 1);
      Reset = 1'b1;
      #1;
      check("async_hit", 32'(duck_hit), 0);
      check("async_bg", 32'(background), 0);
      check("async_status", 32'(duck_status), 0);
      check("async_hits", 32'(hits), 0);
      BallX = 10'd250; BallY = 10'd225; MouseButtons = 8'd2;
      step(2);
      Reset = 1'b0;
      step(6);
      check("held_no_start", 32'({start_game_signal, background}), 0);
      MouseButtons = 8'd0;
      step(3);
      check("release_no_start", 32'(background), 0);
      do_click(10'd250, 10'd225);
      check("repress_start", 32'(start_game_signal), 1);
      check("repress_bg", 32'(background), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
